// File: rtl/imem_loader.sv
// Boot loader: packs a valid/ready byte stream into 32-bit little-endian words and writes them to instruction memory.
// imem_we rises one cycle after a word completes and holds until imem_ready; the core stays in reset until the image is written.
module imem_loader #(
   parameter int unsigned DEPTH_WORDS = 256,
   parameter logic [31:0] BASE_ADDR   = 32'h0000_0000
) (
   input  logic                          clk,
   input  logic                          reset,
   input  logic                          start,
   input  logic                          in_valid,
   input  logic [7:0]                    in_data,
   input  logic                          in_last,
   output logic                          in_ready,
   output logic                          imem_we,
   output logic [31:0]                   imem_addr,
   output logic [31:0]                   imem_wdata,
   input  logic                          imem_ready,
   output logic                          cpu_hold,
   output logic                          done,
   output logic                          error,
   output logic [$clog2(DEPTH_WORDS):0]  word_count
);

   localparam int WCW = $clog2(DEPTH_WORDS) + 1;
   localparam logic [WCW-1:0] DEPTH_W = WCW'(DEPTH_WORDS);

   localparam logic [2:0] S_IDLE    = 3'd0;
   localparam logic [2:0] S_COLLECT = 3'd1;
   localparam logic [2:0] S_WRITE   = 3'd2;
   localparam logic [2:0] S_DONE    = 3'd3;
   localparam logic [2:0] S_ERROR   = 3'd4;

   logic [2:0] state;
   logic [1:0] idx;
   logic       last_flag;
   logic       accept;
   logic       word_end;
   logic       wr_accept;

   // in_ready is only ever high in COLLECT, so accept implies COLLECT.
   assign accept    = in_valid && in_ready;
   assign word_end  = accept && ((idx == 2'd3) || in_last);
   assign wr_accept = imem_we && imem_ready;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state      <= S_IDLE;
         in_ready   <= 1'b0;
         imem_we    <= 1'b0;
         imem_addr  <= BASE_ADDR;
         imem_wdata <= '0;
         cpu_hold   <= 1'b1;
         done       <= 1'b0;
         error      <= 1'b0;
         word_count <= '0;
         idx        <= '0;
         last_flag  <= 1'b0;
      end else begin
         case (state)
            S_IDLE, S_DONE, S_ERROR: begin
               if (start) begin
                  state      <= S_COLLECT;
                  in_ready   <= 1'b1;
                  word_count <= '0;
                  idx        <= '0;
                  last_flag  <= 1'b0;
                  imem_wdata <= '0;
                  cpu_hold   <= 1'b1;
                  done       <= 1'b0;
                  error      <= 1'b0;
               end
            end
            S_COLLECT: begin
               if (accept) begin
                  imem_wdata[8*idx +: 8] <= in_data;
                  idx                    <= idx + 2'd1;
                  if (word_end) begin
                     in_ready  <= 1'b0;
                     last_flag <= in_last;
                     // Overflow is detected before any write is issued for the extra word.
                     if (word_count == DEPTH_W) begin
                        state <= S_ERROR;
                        error <= 1'b1;
                     end else begin
                        state     <= S_WRITE;
                        imem_we   <= 1'b1;
                        imem_addr <= BASE_ADDR + (32'(word_count) << 2);
                     end
                  end
               end
            end
            S_WRITE: begin
               if (wr_accept) begin
                  imem_we    <= 1'b0;
                  word_count <= word_count + 1'b1;
                  idx        <= '0;
                  imem_wdata <= '0;
                  if (last_flag) begin
                     state    <= S_DONE;
                     cpu_hold <= 1'b0;
                     done     <= 1'b1;
                  end else begin
                     state    <= S_COLLECT;
                     in_ready <= 1'b1;
                  end
               end
            end
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader: a default-depth instance and a DEPTH_WORDS=2 instance share one stimulus stream.
module tb_imem_loader;

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic        start = 1'b0;
   logic        in_valid = 1'b0;
   logic [7:0]  in_data = 8'h00;
   logic        in_last = 1'b0;
   logic        imem_ready = 1'b1;

   logic        in_ready, imem_we, cpu_hold, done, error;
   logic [31:0] imem_addr, imem_wdata;
   logic [8:0]  word_count;

   logic        in_ready2, imem_we2, cpu_hold2, done2, error2;
   logic [31:0] imem_addr2, imem_wdata2;
   logic [1:0]  word_count2;

   int errors = 0;
   int checks = 0;
   logic [63:0] wq[$];
   logic [63:0] wq2[$];

   always #5 clk = ~clk;

   imem_loader dut (
      .clk(clk), .reset(reset), .start(start),
      .in_valid(in_valid), .in_data(in_data), .in_last(in_last), .in_ready(in_ready),
      .imem_we(imem_we), .imem_addr(imem_addr), .imem_wdata(imem_wdata), .imem_ready(imem_ready),
      .cpu_hold(cpu_hold), .done(done), .error(error), .word_count(word_count)
   );

   imem_loader #(.DEPTH_WORDS(2)) dut2 (
      .clk(clk), .reset(reset), .start(start),
      .in_valid(in_valid), .in_data(in_data), .in_last(in_last), .in_ready(in_ready2),
      .imem_we(imem_we2), .imem_addr(imem_addr2), .imem_wdata(imem_wdata2), .imem_ready(imem_ready),
      .cpu_hold(cpu_hold2), .done(done2), .error(error2), .word_count(word_count2)
   );

   // Writes are recorded mid-cycle; the handshake completes on the following rising edge.
   always @(negedge clk) begin
      if (reset && imem_we && imem_ready)  wq.push_back({imem_addr, imem_wdata});
      if (reset && imem_we2 && imem_ready) wq2.push_back({imem_addr2, imem_wdata2});
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic tick(input int n);
      for (int i = 0; i < n; i++) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic pulse_start();
      start = 1'b1;
      tick(1);
      start = 1'b0;
   endtask

   task automatic send_byte(input logic [7:0] b, input logic l);
      int n;
      n = 0;
      in_valid = 1'b1;
      in_data  = b;
      in_last  = l;
      while (!in_ready && n < 50) begin
         tick(1);
         n++;
      end
      if (n >= 50) check("in_ready_timeout", 32'(n), 32'd0);
      tick(1);
      in_valid = 1'b0;
      in_last  = 1'b0;
   endtask

   task automatic expect_write(input string tag, input logic [31:0] a, input logic [31:0] d);
      logic [63:0] w;
      w = (wq.size() > 0) ? wq.pop_front() : 64'hFFFF_FFFF_FFFF_FFFF;
      check({tag, "_addr"}, w[63:32], a);
      check({tag, "_data"}, w[31:0], d);
   endtask

   task automatic expect_write2(input string tag, input logic [31:0] a, input logic [31:0] d);
      logic [63:0] w;
      w = (wq2.size() > 0) ? wq2.pop_front() : 64'hFFFF_FFFF_FFFF_FFFF;
      check({tag, "_addr"}, w[63:32], a);
      check({tag, "_data"}, w[31:0], d);
   endtask

   initial begin
      logic [7:0] img1 [8];
      img1 = '{8'h13, 8'h05, 8'h00, 8'h00, 8'h93, 8'h05, 8'h10, 8'h00};

      // Reset and idle without start
      tick(3);
      reset = 1'b1;
      tick(6);
      check("idle_cpu_hold", 32'(cpu_hold), 32'd1);
      check("idle_in_ready", 32'(in_ready), 32'd0);
      check("idle_imem_we", 32'(imem_we), 32'd0);
      check("idle_done", 32'(done), 32'd0);
      check("idle_error", 32'(error), 32'd0);
      check("idle_word_count", 32'(word_count), 32'd0);
      check("idle_addr", imem_addr, 32'h0);

      // Two-word image
      pulse_start();
      check("t1_in_ready", 32'(in_ready), 32'd1);
      for (int i = 0; i < 4; i++) send_byte(img1[i], 1'b0);
      check("t1_we_latency", 32'(imem_we), 32'd1);
      check("t1_in_ready_wr", 32'(in_ready), 32'd0);
      check("t1_cpu_hold_wr", 32'(cpu_hold), 32'd1);
      for (int i = 4; i < 8; i++) send_byte(img1[i], i == 7);
      tick(2);
      check("t1_nwrites", 32'(wq.size()), 32'd2);
      expect_write("t1_w1", 32'h0, 32'h0000_0513);
      expect_write("t1_w2", 32'h4, 32'h0010_0593);
      check("t1_done", 32'(done), 32'd1);
      check("t1_cpu_hold", 32'(cpu_hold), 32'd0);
      check("t1_word_count", 32'(word_count), 32'd2);
      check("t1_we_off", 32'(imem_we), 32'd0);

      // Reload with a partial final word
      wq.delete();
      pulse_start();
      check("t2_cpu_hold_reload", 32'(cpu_hold), 32'd1);
      check("t2_done_clear", 32'(done), 32'd0);
      send_byte(8'hAA, 1'b0); send_byte(8'hBB, 1'b0);
      send_byte(8'hCC, 1'b0); send_byte(8'hDD, 1'b0);
      send_byte(8'h11, 1'b0); send_byte(8'h22, 1'b1);
      tick(2);
      check("t2_nwrites", 32'(wq.size()), 32'd2);
      expect_write("t2_w1", 32'h0, 32'hDDCC_BBAA);
      expect_write("t2_w2", 32'h4, 32'h0000_2211);
      check("t2_done", 32'(done), 32'd1);
      check("t2_word_count", 32'(word_count), 32'd2);

      // Memory stall during the write
      wq.delete();
      wq2.delete();
      imem_ready = 1'b0;
      pulse_start();
      send_byte(8'h01, 1'b0); send_byte(8'h02, 1'b0);
      send_byte(8'h03, 1'b0); send_byte(8'h04, 1'b1);
      in_valid = 1'b1;
      in_data  = 8'h55;
      for (int i = 0; i < 3; i++) begin
         check("t3_we_hold", 32'(imem_we), 32'd1);
         check("t3_addr_hold", imem_addr, 32'h0);
         check("t3_data_hold", imem_wdata, 32'h0403_0201);
         check("t3_in_ready", 32'(in_ready), 32'd0);
         tick(1);
      end
      in_valid = 1'b0;
      imem_ready = 1'b1;
      check("t3_we_4th", 32'(imem_we), 32'd1);
      check("t3_data_4th", imem_wdata, 32'h0403_0201);
      tick(1);
      check("t3_we_after", 32'(imem_we), 32'd0);
      check("t3_word_count", 32'(word_count), 32'd1);
      check("t3_nwrites", 32'(wq.size()), 32'd1);
      check("t3_done", 32'(done), 32'd1);
      wq.delete();
      wq2.delete();

      // Overflow on the two-word instance
      pulse_start();
      for (int i = 0; i < 12; i++) send_byte(8'(i + 1), i == 11);
      check("t4_error", 32'(error2), 32'd1);
      check("t4_cpu_hold", 32'(cpu_hold2), 32'd1);
      check("t4_in_ready", 32'(in_ready2), 32'd0);
      tick(3);
      check("t4_nwrites", 32'(wq2.size()), 32'd2);
      expect_write2("t4_w1", 32'h0, 32'h0403_0201);
      expect_write2("t4_w2", 32'h4, 32'h0807_0605);
      check("t4_no_we", 32'(imem_we2), 32'd0);
      check("t4_done", 32'(done2), 32'd0);
      check("t4_error_hold", 32'(error2), 32'd1);
      pulse_start();
      check("t4_error_clear", 32'(error2), 32'd0);
      check("t4_wc_clear", 32'(word_count2), 32'd0);

      // Asynchronous reset in the middle of a write
      imem_ready = 1'b0;
      send_byte(8'h10, 1'b0); send_byte(8'h20, 1'b0);
      send_byte(8'h30, 1'b0); send_byte(8'h40, 1'b0);
      check("t5_we_before", 32'(imem_we), 32'd1);
      #2;
      reset = 1'b0;
      #1;
      check("t5_we_async", 32'(imem_we), 32'd0);
      check("t5_hold_async", 32'(cpu_hold), 32'd1);
      #4;
      reset = 1'b1;
      imem_ready = 1'b1;
      tick(2);
      check("t5_word_count", 32'(word_count), 32'd0);
      check("t5_in_ready", 32'(in_ready), 32'd0);
      check("t5_addr", imem_addr, 32'h0);
      check("t5_done", 32'(done), 32'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/imem_loader.md
Name: imem_loader

Overview:
- Boot-time program loader; the writer side of the instruction memory that the single-cycle core fetches from.
- Accepts a byte stream over a valid/ready handshake and packs it into 32-bit little-endian words.
- Writes each word to consecutive instruction-memory addresses.
- Holds the core's PC reset asserted until the whole image is written, then releases it.

Parameters:
- DEPTH_WORDS, 256, instruction memory capacity in 32-bit words.
- BASE_ADDR, 32'h0000_0000, byte address of the first word written. Must be 4-byte aligned.

Ports:
- clk  input  1  system clock; all state changes on rising edge.
- reset  input  1  asynchronous, active-low reset.
- start  input  1  single-cycle pulse; begins a load. Honoured only in IDLE, DONE or ERROR.
- in_valid  input  1  byte on in_data is valid.
- in_data  input  8  program byte.
- in_last  input  1  qualifies the byte as the final byte of the image.
- in_ready  output  1  loader accepts a byte this cycle.
- imem_we  output  1  instruction-memory write request.
- imem_addr  output  32  byte address of the word being written.
- imem_wdata  output  32  word being written.
- imem_ready  input  1  memory accepts the write this cycle.
- cpu_hold  output  1  drives the core's PCreset; 1 holds the core in reset.
- done  output  1  image loaded, core released.
- error  output  1  image exceeded DEPTH_WORDS.
- word_count  output  clog2(DEPTH_WORDS)+1  words written in the current load.

Behaviour:
- All outputs are registered.
- Reset (asynchronous, takes effect immediately, including mid-write):
  - state=IDLE, in_ready=0, imem_we=0, imem_addr=BASE_ADDR, imem_wdata=0.
  - cpu_hold=1, done=0, error=0, word_count=0, byte index=0, last flag=0.
- FSM states: IDLE, COLLECT, WRITE, DONE, ERROR.
- IDLE: cpu_hold=1. start -> COLLECT; clears word_count, byte index, last flag and imem_wdata.
- COLLECT:
  - in_ready=1. A byte is accepted on a cycle where in_valid && in_ready.
  - The accepted byte is stored in imem_wdata[8*idx+7 : 8*idx], then idx increments.
  - After the 4th byte (idx was 3), or after any byte with in_last=1:
    - Unfilled upper bytes stay 0x00.
    - in_last is latched into the last flag.
    - Next state is WRITE; in_ready is 0 from the following cycle.
  - If word_count==DEPTH_WORDS when the word completes, go to ERROR instead of WRITE. No write is issued.
- WRITE:
  - imem_we=1, imem_addr=BASE_ADDR+4*word_count, imem_wdata stable; in_ready=0.
  - All three are held until a cycle where imem_we && imem_ready.
  - On that cycle: word_count+1, idx=0, imem_wdata cleared.
  - Next state: DONE if the last flag is set, else COLLECT.
  - imem_we is 0 in the cycle after acceptance.
- Latency: imem_we rises on the cycle after the 4th byte is accepted. Best-case throughput is one word per 5 cycles.
- DONE: cpu_hold=0, done=1, in_ready=0, imem_we=0.
  - start -> COLLECT; cpu_hold=1 and done=0 on the next cycle. This reloads the image.
- ERROR: error=1, cpu_hold=1, in_ready=0, imem_we=0.
  - start -> COLLECT; error=0 and counters cleared.
- start in COLLECT or WRITE is ignored.
- in_valid while in_ready=0 is not accepted; the source must hold the byte.
- in_last with an empty image (no bytes) cannot occur: in_last always accompanies a byte.
- cpu_hold changes only on state transitions, never mid-word.

Test Plan:
- Reset release, no start -> cpu_hold=1, in_ready=0, imem_we=0, done=0 indefinitely.
- start, bytes 13 05 00 00 93 05 10 00 with in_last on the 8th byte, imem_ready tied 1:
  - Write #1: addr 0x0, data 0x00000513.
  - Write #2: addr 0x4, data 0x00100593.
  - Then done=1, cpu_hold=0, word_count=2.
- 6 bytes AA BB CC DD 11 22, in_last on 22:
  - Second write: addr 0x4, data 0x00002211.
  - done=1.
- imem_ready held 0 for 3 cycles during the first write:
  - imem_we/addr/wdata stable for 4 cycles, in_ready=0 throughout.
  - Write lands once; word_count increments by 1.
- DEPTH_WORDS=2, 12 bytes streamed:
  - Two writes at 0x0 and 0x4.
  - After the 12th byte: error=1, cpu_hold=1, no third imem_we.
  - A following start clears error.
- reset driven low while imem_we=1 in WRITE:
  - imem_we=0 and cpu_hold=1 immediately, before the next clk edge.
  - After release: IDLE, word_count=0.
